// File: rtl/lcd_ctrl_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_pkg
//  Purpose  : Shared definitions for the character-LCD controller: request
//             op codes, HD44780 command bytes, FSM state encoding and small
//             helpers for DDRAM row addressing and the init command list.
//  Revision : 1.0  initial release
// ============================================================================
package lcd_pkg;

    // Request op codes
    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_SETCUR = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_RAW    = 2'd3;

    // HD44780 command bytes
    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    // FSM state encoding
    localparam logic [2:0] S_PWRUP = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_EN_HI = 3'd3;
    localparam logic [2:0] S_EN_LO = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    // DDRAM base address of each display row
    function automatic logic [7:0] row_base(input logic [1:0] row);
        case (row)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

    // Power-up command list, issued in index order
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_8B2L;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY_INC;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ctrl_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_req_if
//  Purpose  : Request channel between the CPU-side register block (master)
//             and the LCD controller (slave).
//  Signals  : req_valid/req_ready handshake, req_op/req_data/req_row/req_col
//             request fields, done completion pulse, cur_row/cur_col cursor.
//  Revision : 1.0  initial release
// ============================================================================
interface lcd_req_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_data;
    logic [1:0] req_row;
    logic [5:0] req_col;
    logic       done;
    logic [1:0] cur_row;
    logic [5:0] cur_col;

    modport master (
        output req_valid, req_op, req_data, req_row, req_col,
        input  req_ready, done, cur_row, cur_col
    );

    modport slave (
        input  req_valid, req_op, req_data, req_row, req_col,
        output req_ready, done, cur_row, cur_col
    );
endinterface
`default_nettype wire

// File: rtl/lcd_ctrl_multi_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_tick_gen
//  Purpose  : Free-running divider producing a one-clk enable every TICK_DIV
//             clocks.
//  Ports    : clk, reset_n (async active-low), tick (1-clk enable).
//  Revision : 1.0  initial release
// ============================================================================
module lcd_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule
`default_nettype wire

// File: rtl/lcd_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_ctrl_multi
//  Purpose  : HD44780-compatible 8-bit write-only LCD controller with
//             COLS x ROWS geometry, cursor tracking, auto line wrap and a
//             valid/ready request channel.
//  Ports    : clk, reset_n (async active-low), req (lcd_req_if.slave),
//             LCD_ON/LCD_BLON/LCD_RW constants, LCD_EN/LCD_RS/LCD_DATA bus.
//  Revision : 1.0  initial release
// ============================================================================
module lcd_ctrl_multi
    import lcd_pkg::*;
#(
    parameter int TICK_DIV       = 50000,
    parameter int COLS           = 16,
    parameter int ROWS           = 2,
    parameter int PWRUP_TICKS    = 20,
    parameter int CMD_WAIT_TICKS = 1,
    parameter int CLR_WAIT_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    lcd_req_if.slave   req,
    output logic       LCD_ON,
    output logic       LCD_BLON,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic [7:0] LCD_DATA
);
    localparam int MAX_A  = (PWRUP_TICKS > CMD_WAIT_TICKS) ? PWRUP_TICKS : CMD_WAIT_TICKS;
    localparam int MAX_T  = (MAX_A > CLR_WAIT_TICKS) ? MAX_A : CLR_WAIT_TICKS;
    localparam int CNT_W  = $clog2(MAX_T + 1);
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWRUP_TICKS - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_TICKS - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT_TICKS - 1);
    localparam logic [5:0] COL_MAX = 6'(COLS - 1);
    localparam logic [1:0] ROW_MAX = 2'(ROWS - 1);

    logic tick;

    lcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    logic [2:0]       state_q, state_d;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             init_q, init_d;     // running the power-up command list
    logic [1:0]       idx_q, idx_d;
    logic             pend_q, pend_d;     // address cmd sent, data byte still due
    logic [1:0]       op_q, op_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [1:0]       row_q, row_d;
    logic [5:0]       col_q, col_d;
    logic             dirty_q, dirty_d;   // LCD address counter may differ from cursor
    logic             done_q, done_d;
    logic [CNT_W-1:0] wait_last;

    // A clear instruction needs the longer settle time regardless of origin
    assign wait_last = (!rs_q && data_q == CMD_CLEAR) ? CLR_LAST : CMD_LAST;

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        row_d   = row_q;
        col_d   = col_q;
        dirty_d = dirty_q;
        done_d  = 1'b0;

        case (state_q)
            S_PWRUP: if (tick) begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    init_d  = 1'b1;
                    idx_d   = 2'd0;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(2'd0);
                    state_d = S_SETUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: if (req.req_valid) begin
                op_d    = req.req_op;
                wdata_d = req.req_data;
                case (req.req_op)
                    OP_WRITE: begin
                        state_d = S_SETUP;
                        if (dirty_q) begin
                            rs_d    = 1'b0;
                            data_d  = CMD_SET_DDRAM | (row_base(row_q) + {2'b00, col_q});
                            pend_d  = 1'b1;
                            dirty_d = 1'b0;
                        end else begin
                            rs_d   = 1'b1;
                            data_d = req.req_data;
                            pend_d = 1'b0;
                        end
                    end
                    OP_SETCUR: begin
                        row_d   = (req.req_row > ROW_MAX) ? ROW_MAX : req.req_row;
                        col_d   = (req.req_col > COL_MAX) ? COL_MAX : req.req_col;
                        dirty_d = 1'b1;
                        done_d  = 1'b1;
                    end
                    OP_CLEAR: begin
                        state_d = S_SETUP;
                        rs_d    = 1'b0;
                        data_d  = CMD_CLEAR;
                        pend_d  = 1'b0;
                    end
                    default: begin
                        state_d = S_SETUP;
                        rs_d    = 1'b0;
                        data_d  = req.req_data;
                        pend_d  = 1'b0;
                    end
                endcase
            end
            S_SETUP: if (tick) begin
                en_d    = 1'b1;
                state_d = S_EN_HI;
            end
            S_EN_HI: if (tick) begin
                en_d    = 1'b0;
                state_d = S_EN_LO;
            end
            S_EN_LO: if (tick) begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: if (tick) begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    if (init_q) begin
                        if (idx_q == 2'd3) begin
                            init_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            rs_d    = 1'b0;
                            data_d  = init_cmd(idx_q + 2'd1);
                            state_d = S_SETUP;
                        end
                    end else if (pend_q) begin
                        pend_d  = 1'b0;
                        rs_d    = 1'b1;
                        data_d  = wdata_q;
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        case (op_q)
                            OP_WRITE: begin
                                if (col_q == COL_MAX) begin
                                    col_d   = 6'd0;
                                    row_d   = (row_q == ROW_MAX) ? 2'd0 : row_q + 2'd1;
                                    dirty_d = 1'b1;
                                end else begin
                                    col_d = col_q + 6'd1;
                                end
                            end
                            OP_CLEAR: begin
                                row_d   = 2'd0;
                                col_d   = 6'd0;
                                dirty_d = 1'b0;
                            end
                            default: dirty_d = 1'b1;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_PWRUP;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            cnt_q   <= '0;
            init_q  <= 1'b0;
            idx_q   <= 2'd0;
            pend_q  <= 1'b0;
            op_q    <= 2'd0;
            wdata_q <= 8'h00;
            row_q   <= 2'd0;
            col_q   <= 6'd0;
            dirty_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dirty_q <= dirty_d;
            done_q  <= done_d;
        end
    end

    assign req.req_ready = (state_q == S_IDLE);
    assign req.done      = done_q;
    assign req.cur_row   = row_q;
    assign req.cur_col   = col_q;

    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b0;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = en_q;
    assign LCD_RS   = rs_q;
    assign LCD_DATA = data_q;
endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_ctrl_multi
//  Purpose  : Directed self-checking bench for lcd_ctrl_multi (TICK_DIV=4,
//             PWRUP_TICKS=3, CMD_WAIT_TICKS=1, CLR_WAIT_TICKS=2, 16x2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lcd_ctrl_multi;
    import lcd_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    lcd_req_if req_if ();
    logic       LCD_ON, LCD_BLON, LCD_RW, LCD_EN, LCD_RS;
    logic [7:0] LCD_DATA;

    lcd_ctrl_multi #(
        .TICK_DIV(4), .COLS(16), .ROWS(2),
        .PWRUP_TICKS(3), .CMD_WAIT_TICKS(1), .CLR_WAIT_TICKS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req_if),
        .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_DATA(LCD_DATA)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Bus monitor: records {RS,DATA} and cycle of every EN rising edge
    int         cyc;
    logic       prev_en  = 1'b0;
    logic [8:0] ev_q[$];
    int         ev_cyc[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         rdy_cyc  = 0;
    bit         rdy_seen = 1'b0;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_en  = 1'b0;
            rdy_seen = 1'b0;
        end else begin
            if (LCD_EN && !prev_en) begin
                ev_q.push_back({LCD_RS, LCD_DATA});
                ev_cyc.push_back(cyc);
            end
            prev_en = LCD_EN;
            if (req_if.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (req_if.req_ready && !rdy_seen) begin
                rdy_seen = 1'b1;
                rdy_cyc  = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d,
                        input logic [1:0] r, input logic [5:0] c);
        int n = 0;
        @(negedge clk);
        req_if.req_op    = op;
        req_if.req_data  = d;
        req_if.req_row   = r;
        req_if.req_col   = c;
        req_if.req_valid = 1'b1;
        while (!req_if.req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_if.req_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_if.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!req_if.done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_if.done) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic write_ch(input logic [7:0] ch);
        send(OP_WRITE, ch, 2'd0, 6'd0);
        wait_done("write");
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_if.req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_if.req_ready) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        #1;
    endtask

    // Init sequence: EN rises 16 clks after release, 16 clks apart except the
    // clear (20 clks); ready rises at clk 80.
    task automatic check_init(input string tag, input int base);
        logic [7:0] cmds [4];
        int         cyc_exp [4];
        cmds    = '{8'h38, 8'h0C, 8'h01, 8'h06};
        cyc_exp = '{16, 32, 48, 68};
        chk({tag, "_ev_count"}, 32'(ev_q.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < ev_q.size()) begin
                chk($sformatf("%s_cmd%0d", tag, i), 32'(ev_q[base + i]), {23'd0, 1'b0, cmds[i]});
                chk($sformatf("%s_cyc%0d", tag, i), 32'(ev_cyc[base + i]), 32'(cyc_exp[i]));
            end
        end
        chk({tag, "_ready_cyc"}, 32'(rdy_cyc), 32'd80);
    endtask

    initial begin
        int base;
        int d0;
        int e_cyc;
        req_if.req_valid = 1'b0;
        req_if.req_op    = 2'd0;
        req_if.req_data  = 8'h00;
        req_if.req_row   = 2'd0;
        req_if.req_col   = 6'd0;

        // Reset state
        #1;
        chk("rst_en",    32'(LCD_EN), 32'd0);
        chk("rst_rs",    32'(LCD_RS), 32'd0);
        chk("rst_data",  32'(LCD_DATA), 32'h00);
        chk("rst_ready", 32'(req_if.req_ready), 32'd0);
        chk("rst_done",  32'(req_if.done), 32'd0);
        chk("rst_cur",   {24'd0, req_if.cur_row, req_if.cur_col}, 32'd0);
        chk("rst_const", {29'd0, LCD_ON, LCD_BLON, LCD_RW}, 32'b100);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;

        // Init sequence
        base = ev_q.size();
        wait_ready("init");
        check_init("init", base);

        // Line wrap: 17 writes 'A'..'Q'
        base = ev_q.size();
        d0   = done_cnt;
        for (int i = 0; i < 17; i++) write_ch(8'(8'h41 + i));
        chk("wrap_ev_count", 32'(ev_q.size() - base), 32'd18);
        if (ev_q.size() - base == 18) begin
            chk("wrap_first_A", 32'(ev_q[base]),      32'h141);
            chk("wrap_P",       32'(ev_q[base + 15]), 32'h150);
            chk("wrap_addr_C0", 32'(ev_q[base + 16]), 32'h0C0);
            chk("wrap_Q",       32'(ev_q[base + 17]), 32'h151);
        end
        chk("wrap_cur_row", 32'(req_if.cur_row), 32'd1);
        chk("wrap_cur_col", 32'(req_if.cur_col), 32'd1);
        chk("wrap_done_cnt", 32'(done_cnt - d0), 32'd17);

        // Row wrap at last row
        send(OP_SETCUR, 8'h00, 2'd1, 6'd15);
        wait_done("setcur");
        base = ev_q.size();
        write_ch(8'h5A);
        write_ch(8'h59);
        chk("rowwrap_ev_count", 32'(ev_q.size() - base), 32'd4);
        if (ev_q.size() - base == 4) begin
            chk("rowwrap_CF", 32'(ev_q[base]),     32'h0CF);
            chk("rowwrap_Z",  32'(ev_q[base + 1]), 32'h15A);
            chk("rowwrap_80", 32'(ev_q[base + 2]), 32'h080);
            chk("rowwrap_Y",  32'(ev_q[base + 3]), 32'h159);
        end
        chk("rowwrap_cur", {24'd0, req_if.cur_row, req_if.cur_col}, {24'd0, 2'd0, 6'd1});

        // Saturation
        base = ev_q.size();
        send(OP_SETCUR, 8'h00, 2'd3, 6'd63);
        chk("sat_done_pulse", 32'(req_if.done), 32'd1);
        @(posedge clk);
        #1;
        chk("sat_done_one_clk", 32'(req_if.done), 32'd0);
        chk("sat_no_en", 32'(ev_q.size() - base), 32'd0);
        chk("sat_cur_row", 32'(req_if.cur_row), 32'd1);
        chk("sat_cur_col", 32'(req_if.cur_col), 32'd15);
        write_ch(8'h58);
        chk("sat_ev_count", 32'(ev_q.size() - base), 32'd2);
        if (ev_q.size() - base == 2) begin
            chk("sat_addr_CF", 32'(ev_q[base]),     32'h0CF);
            chk("sat_X",       32'(ev_q[base + 1]), 32'h158);
        end

        // CLEAR: 2-tick wait, cursor home, no address cmd afterwards
        base = ev_q.size();
        send(OP_CLEAR, 8'h00, 2'd0, 6'd0);
        wait_done("clear");
        chk("clr_ev_count", 32'(ev_q.size() - base), 32'd1);
        if (ev_q.size() - base == 1) begin
            chk("clr_cmd", 32'(ev_q[base]), 32'h001);
            e_cyc = ev_cyc[base];
            chk("clr_en_to_done", 32'(done_cyc - e_cyc), 32'd16);
        end
        chk("clr_cur", {24'd0, req_if.cur_row, req_if.cur_col}, 32'd0);
        base = ev_q.size();
        write_ch(8'h57);
        chk("clr_next_ev_count", 32'(ev_q.size() - base), 32'd1);
        if (ev_q.size() - base == 1) begin
            chk("clr_next_W", 32'(ev_q[base]), 32'h157);
            e_cyc = ev_cyc[base];
            chk("write_en_to_done", 32'(done_cyc - e_cyc), 32'd12);
        end
        chk("clr_next_cur_col", 32'(req_if.cur_col), 32'd1);

        // Reset mid-transaction
        send(OP_WRITE, 8'h52, 2'd0, 6'd0);
        begin
            int n = 0;
            while (!LCD_EN && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("midrst_en_seen", 32'(LCD_EN), 32'd1);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_en_low",    32'(LCD_EN), 32'd0);
        chk("midrst_ready_low", 32'(req_if.req_ready), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        base = ev_q.size();
        wait_ready("reinit");
        check_init("reinit", base);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lcd_ctrl_multi.md
Name: lcd_ctrl_multi

Overview:
- Parametrised successor character-LCD controller (HD44780-compatible, 8-bit bus, write-only).
- Generalised in geometry (COLS x ROWS, 1/2/4 rows) and timing (clock-enable tick instead of derived clock).
- Adds explicit cursor addressing, auto line wrap, clear/raw-command ops and a valid/ready request handshake.
- Sits between the CPU's memory-mapped LCD register and the board LCD pins.

Parameters:
- TICK_DIV, 50000, clk cycles per LCD tick (1 ms at 50 MHz); minimum 2.
- COLS, 16, characters per row; 1..40.
- ROWS, 2, rows; 1, 2 or 4 only.
- PWRUP_TICKS, 20, ticks held idle after reset before the init sequence.
- CMD_WAIT_TICKS, 1, ticks waited after each non-clear bus transaction.
- CLR_WAIT_TICKS, 2, ticks waited after a clear (0x01) transaction.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: controller accepts a request this cycle.
- req_op, in, 2: 0 WRITE char, 1 SET_CURSOR, 2 CLEAR, 3 RAW command.
- req_data, in, 8: character (WRITE) or command byte (RAW).
- req_row, in, 2: target row (SET_CURSOR).
- req_col, in, 6: target column (SET_CURSOR).
- done, out, 1: one-clk pulse when an accepted request completes.
- cur_row, out, 2: current cursor row.
- cur_col, out, 6: current cursor column.
- LCD_ON, out, 1: constant 1.
- LCD_BLON, out, 1: constant 0.
- LCD_RW, out, 1: constant 0.
- LCD_EN, out, 1: LCD strobe.
- LCD_RS, out, 1: 0 command, 1 data.
- LCD_DATA, out, 8: bus data.

Behaviour:
- Reset (async, reset_n low): LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, req_ready=0, done=0, cur_row=0, cur_col=0, addr_dirty=0, state=S_PWRUP, tick counter=0.
- The tick is a one-clk enable every TICK_DIV clks. All FSM advancement is gated by the tick except S_IDLE accept and the done pulse, which run at clk rate.
- Bus transaction, given RS/DATA:
  - S_SETUP: drive RS/DATA with EN=0 for 1 tick.
  - S_EN_HI: EN=1 for 1 tick.
  - S_EN_LO: EN=0.
  - S_WAIT: CMD_WAIT_TICKS, or CLR_WAIT_TICKS when DATA=0x01 and RS=0.
  - RS/DATA are held stable from S_SETUP through the end of S_WAIT.
- Init: after PWRUP_TICKS, issue 0x38, 0x0C, 0x01, 0x06 in order, one transaction each, then enter S_IDLE. Requests are not accepted during init.
- Handshake: req_ready=1 only in S_IDLE. Accept happens on the clk edge with req_valid & req_ready. The request is latched and req_ready drops on the next clk.
- WRITE:
  - If addr_dirty, first issue command (0x80 | base[row] + col), then the data transaction with RS=1.
  - Row bases: 0x00, 0x40, 0x14, 0x54 (ROWS=1 uses 0x00 only).
  - After the data transaction: col+1. If the old col == COLS-1, set col=0 and row=(row==ROWS-1)?0:row+1, and set addr_dirty=1.
- SET_CURSOR: saturate row to ROWS-1 and col to COLS-1, update the cursor, set addr_dirty=1. No bus transaction is issued; done pulses 1 clk after accept.
- CLEAR: issue 0x01, then set cursor to 0,0 and addr_dirty=0.
- RAW: issue req_data with RS=0, then set addr_dirty=1. Cursor is unchanged.
- done: one-clk pulse on the clk after the final S_WAIT of the request completes. The FSM returns to S_IDLE in the same cycle.
- req_valid in non-idle states is ignored; it is not queued. The requester must hold req_valid until req_ready.
- Reset mid-transaction: immediate abort, EN=0, full re-init from S_PWRUP.
- Width rule: col compare uses 6 bits. COLS-1 must fit in 6 bits (COLS<=40 guaranteed).

Decomposition:
- Package lcd_pkg holds:
  - op codes (OP_WRITE/OP_SETCUR/OP_CLEAR/OP_RAW);
  - HD44780 constants (CMD_FUNC_8B2L=0x38, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY_INC=0x06, CMD_SET_DDRAM=0x80);
  - row base address table;
  - FSM state encoding.
- Sub-module lcd_tick_gen (parameter TICK_DIV): free-running counter producing the 1-clk tick enable; async active-low reset to 0.

Test Plan:
- Use TICK_DIV=4, PWRUP_TICKS=3, CMD_WAIT_TICKS=1, CLR_WAIT_TICKS=2 for all scenarios.
- Init: release reset_n -> no EN pulse for 3 ticks, then exactly 4 EN pulses with DATA 0x38, 0x0C, 0x01, 0x06, RS=0. req_ready rises only after the last wait.
- Line wrap (COLS=16, ROWS=2): 17 WRITEs 'A'..'Q' -> first data preceded by no address cmd. Before 'Q', command 0xC0 is issued. Final cur_row=1, cur_col=1. 17 done pulses.
- Row wrap at last row: SET_CURSOR(1,15), WRITE 'Z', WRITE 'Y' -> sequence 0xCF, 'Z', 0x80, 'Y'. Final cursor 0,1.
- Saturation: SET_CURSOR(row=3, col=63) with ROWS=2 -> cur_row=1, cur_col=15. done 1 clk after accept with no EN pulse. Next WRITE emits 0xCF.
- CLEAR timing: CLEAR after writes -> 0x01 with a 2-tick wait, cursor 0,0. Next WRITE emits no address cmd.
- Reset mid-transaction: assert reset_n low while LCD_EN=1 -> LCD_EN=0 and req_ready=0 immediately. After release, the full init sequence repeats.
